// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and timing helpers for the key click classifier
package key_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS1,
      WAIT2,
      PRESS2,
      LONG
   } key_state_e;

   function automatic int ms_to_cycles(input int freq_mhz, input int ms);
      return freq_mhz * 1000 * ms;
   endfunction

   // Wide enough to hold the largest terminal count with one bit of headroom.
   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/key_interval_timer.sv
// rtl/key_interval_timer.sv - clear/enable interval counter with terminal-count expire
module key_interval_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         enable_i,
   input  logic [W-1:0] tc_i,
   output logic         expire_o
);

   logic [W-1:0] count_q, count_d;

   // Expiry restarts the count so periodic use never wraps.
   always_comb begin
      expire_o = enable_i && (tc_i != '0) && (count_q == tc_i - W'(1));
      count_d  = count_q;
      if (clear_i || expire_o)
         count_d = '0;
      else if (enable_i)
         count_d = count_q + W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

// File: rtl/key_click_classifier.sv
// rtl/key_click_classifier.sv - single/double/long-press gesture classifier for one key
module key_click_classifier #(
   parameter int CLK_FREQ_MHZ = 100,
   parameter int LONG_MS      = 1000,
   parameter int DOUBLE_MS    = 300,
   parameter int REPEAT_MS    = 200
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       key_down_one_time_i,
   input  logic       key_up_one_time_i,
   output logic       single_click_o,
   output logic       double_click_o,
   output logic       long_start_o,
   output logic       long_repeat_o,
   output logic       long_end_o,
   output logic [7:0] repeat_count_o
);
   import key_pkg::*;

   localparam int LONG_CYC = ms_to_cycles(CLK_FREQ_MHZ, LONG_MS);
   localparam int DBL_CYC  = ms_to_cycles(CLK_FREQ_MHZ, DOUBLE_MS);
   localparam int REP_CYC  = ms_to_cycles(CLK_FREQ_MHZ, REPEAT_MS);
   localparam int TW       = timer_width(LONG_CYC, DBL_CYC, REP_CYC);
   localparam logic [TW-1:0] LONG_TC = TW'(LONG_CYC);
   localparam logic [TW-1:0] DBL_TC  = TW'(DBL_CYC);
   localparam logic [TW-1:0] REP_TC  = TW'(REP_CYC);
   localparam logic          REP_ON  = (REP_CYC != 0);

   key_state_e    state_q;
   logic          single_q, double_q, long_start_q, long_repeat_q, long_end_q;
   logic [7:0]    rc_q;
   logic          up, down;
   logic [TW-1:0] tc;
   logic          tmr_en, restart, expire;

   // A release in the same cycle as a press takes precedence; the press is dropped.
   assign up   = key_up_one_time_i;
   assign down = key_down_one_time_i & ~key_up_one_time_i;

   always_comb begin
      tc      = '0;
      tmr_en  = 1'b0;
      restart = !en_i;
      unique case (state_q)
         IDLE:   restart = restart | down;
         PRESS1: begin tc = LONG_TC; tmr_en = en_i; restart = restart | up | expire; end
         WAIT2:  begin tc = DBL_TC;  tmr_en = en_i; restart = restart | down | expire; end
         PRESS2: restart = restart | up;
         LONG:   begin tc = REP_TC;  tmr_en = en_i & REP_ON; restart = restart | up; end
         default: restart = 1'b1;
      endcase
   end

   key_interval_timer #(.W(TW)) u_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (restart),
      .enable_i (tmr_en),
      .tc_i     (tc),
      .expire_o (expire)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         single_q      <= 1'b0;
         double_q      <= 1'b0;
         long_start_q  <= 1'b0;
         long_repeat_q <= 1'b0;
         long_end_q    <= 1'b0;
         rc_q          <= 8'd0;
      end else begin
         single_q      <= 1'b0;
         double_q      <= 1'b0;
         long_start_q  <= 1'b0;
         long_repeat_q <= 1'b0;
         long_end_q    <= 1'b0;
         if (!en_i) begin
            state_q <= IDLE;
         end else begin
            unique case (state_q)
               IDLE: if (down) state_q <= PRESS1;
               PRESS1: begin
                  if (up) begin
                     state_q <= WAIT2;
                  end else if (expire) begin
                     state_q      <= LONG;
                     long_start_q <= 1'b1;
                     rc_q         <= 8'd0;
                  end
               end
               WAIT2: begin
                  if (down) begin
                     state_q <= PRESS2;
                  end else if (expire) begin
                     state_q  <= IDLE;
                     single_q <= 1'b1;
                  end
               end
               PRESS2: begin
                  if (up) begin
                     state_q  <= IDLE;
                     double_q <= 1'b1;
                  end
               end
               LONG: begin
                  if (up) begin
                     state_q    <= IDLE;
                     long_end_q <= 1'b1;
                  end else if (expire) begin
                     long_repeat_q <= 1'b1;
                     if (rc_q != 8'hFF) rc_q <= rc_q + 8'd1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign single_click_o = single_q;
   assign double_click_o = double_q;
   assign long_start_o   = long_start_q;
   assign long_repeat_o  = long_repeat_q;
   assign long_end_o     = long_end_q;
   assign repeat_count_o = rc_q;

endmodule

// File: tb/tb_key_click_classifier.sv
// tb/tb_key_click_classifier.sv - randomized and directed gesture bench for key_click_classifier
module tb_key_click_classifier;

   localparam int LONG_T = 4000;
   localparam int DBL_T  = 2000;
   localparam int REP_T  = 1000;
   localparam logic [4:0] S  = 5'b10000;
   localparam logic [4:0] D  = 5'b01000;
   localparam logic [4:0] LS = 5'b00100;
   localparam logic [4:0] LR = 5'b00010;
   localparam logic [4:0] LE = 5'b00001;

   logic clk = 1'b0;
   logic rst, en, kd, ku;
   logic a_s, a_d, a_ls, a_lr, a_le;
   logic b_s, b_d, b_ls, b_lr, b_le;
   logic [7:0] a_rc, b_rc;

   int n_checks = 0;
   int n_fail   = 0;
   bit sel      = 1'b0;
   logic [2:0] stim_v[];
   logic [4:0] exp_v[];
   int glen;
   int rc_exp = 0;

   always #5 clk = ~clk;

   key_click_classifier #(.CLK_FREQ_MHZ(1), .LONG_MS(4), .DOUBLE_MS(2), .REPEAT_MS(1)) dut_a (
      .clk_i(clk), .rst_i(rst), .en_i(en),
      .key_down_one_time_i(kd), .key_up_one_time_i(ku),
      .single_click_o(a_s), .double_click_o(a_d), .long_start_o(a_ls),
      .long_repeat_o(a_lr), .long_end_o(a_le), .repeat_count_o(a_rc));

   key_click_classifier #(.CLK_FREQ_MHZ(1), .LONG_MS(4), .DOUBLE_MS(2), .REPEAT_MS(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .en_i(en),
      .key_down_one_time_i(kd), .key_up_one_time_i(ku),
      .single_click_o(b_s), .double_click_o(b_d), .long_start_o(b_ls),
      .long_repeat_o(b_lr), .long_end_o(b_le), .repeat_count_o(b_rc));

   function automatic logic [4:0] vec_now();
      return sel ? {b_s, b_d, b_ls, b_lr, b_le} : {a_s, a_d, a_ls, a_lr, a_le};
   endfunction

   function automatic logic [7:0] rc_now();
      return sel ? b_rc : a_rc;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic clear_stim(input int n);
      glen   = n;
      stim_v = new[n];
      exp_v  = new[n];
      for (int i = 0; i < n; i++) begin
         stim_v[i] = 3'b100;
         exp_v[i]  = 5'b0;
      end
   endtask

   // Gesture outcome from hold/gap durations: press at 0, release at h1,
   // optional second press gap cycles after the release, held h2 cycles.
   task automatic build_gesture(input int h1, input bit two, input int gap, input int h2, input bit rep_on);
      int up1, dn2, up2, n;
      up1 = h1;
      dn2 = up1 + gap;
      up2 = dn2 + h2;
      clear_stim((two ? up2 : up1) + DBL_T + 5);
      stim_v[0]   = 3'b110;
      stim_v[up1] = 3'b101;
      if (h1 <= LONG_T) begin
         if (two) begin
            stim_v[dn2]   = 3'b110;
            stim_v[up2]   = 3'b101;
            exp_v[up2 + 1] = D;
         end else begin
            exp_v[up1 + DBL_T + 1] = S;
         end
      end else begin
         exp_v[LONG_T + 1] = LS;
         n = 0;
         if (rep_on)
            for (int k = 1; LONG_T + REP_T * k < up1; k++) begin
               exp_v[LONG_T + 1 + REP_T * k] = LR;
               n++;
            end
         exp_v[up1 + 1] = LE;
         rc_exp = (n > 255) ? 255 : n;
      end
   endtask

   task automatic run_cycles(input string tag);
      for (int c = 0; c < glen; c++) begin
         @(posedge clk);
         #1;
         en = stim_v[c][2];
         kd = stim_v[c][1];
         ku = stim_v[c][0];
         @(negedge clk);
         check(tag, {3'b000, vec_now()}, {3'b000, exp_v[c]});
      end
   endtask

   task automatic run(input string tag);
      run_cycles(tag);
      check({tag, "_rc"}, rc_now(), 8'(rc_exp));
   endtask

   initial begin
      int h1, gap, h2;
      bit two;
      rst = 1'b0; en = 1'b0; kd = 1'b0; ku = 1'b0;
      #1 rst = 1'b1;
      #1;
      sel = 1'b0;
      check("reset_a_out", {3'b000, vec_now()}, 8'h00);
      check("reset_a_rc", rc_now(), 8'h00);
      sel = 1'b1;
      check("reset_b_out", {3'b000, vec_now()}, 8'h00);
      check("reset_b_rc", rc_now(), 8'h00);
      sel = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;

      clear_stim(30);
      stim_v[2]  = 3'b101;
      stim_v[10] = 3'b111;
      run("ignored_idle");

      build_gesture(500, 1'b0, 0, 0, 1'b1);
      run("single");
      build_gesture(500, 1'b1, 1000, 300, 1'b1);
      run("double");
      build_gesture(6500, 1'b0, 0, 0, 1'b1);
      run("long_repeat");
      build_gesture(5000, 1'b0, 0, 0, 1'b1);
      run("tick_vs_release");
      build_gesture(LONG_T, 1'b0, 0, 0, 1'b1);
      run("long_boundary");
      build_gesture(300, 1'b1, DBL_T, 4500, 1'b1);
      run("double_edge");

      // Asynchronous reset while a repeat pulse is visible.
      build_gesture(6500, 1'b0, 0, 0, 1'b1);
      glen = LONG_T + REP_T + 1;
      run_cycles("rst_lead");
      @(posedge clk);
      #1;
      check("rst_pre_out", {3'b000, vec_now()}, {3'b000, LR});
      check("rst_pre_rc", rc_now(), 8'd1);
      rst = 1'b1;
      #1;
      check("rst_async_out", {3'b000, vec_now()}, 8'h00);
      check("rst_async_rc", rc_now(), 8'h00);
      @(negedge clk);
      rst    = 1'b0;
      rc_exp = 0;

      clear_stim(4800);
      stim_v[0] = 3'b110;
      for (int c = 4500; c < 4600; c++) stim_v[c] = 3'b000;
      stim_v[4700]      = 3'b101;
      exp_v[LONG_T + 1] = LS;
      rc_exp = 0;
      run("en_abort");

      for (int r = 0; r < 2; r++) begin
         h1  = $urandom_range(6000, 1);
         two = (h1 <= LONG_T) && ($urandom_range(1, 0) == 1);
         gap = $urandom_range(DBL_T, 1);
         h2  = $urandom_range(2000, 1);
         build_gesture(h1, two, gap, h2, 1'b1);
         run("random");
      end

      sel = 1'b1;
      build_gesture(10000, 1'b0, 0, 0, 1'b0);
      run("norepeat");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
